// File: rtl/pipeline_run_controller_pkg.sv
// pipeline_run_controller_pkg: shared state encoding and default parameters for the run controller.
package pipeline_run_controller_pkg;
    localparam int RUN_STATE_W      = 3;
    localparam int DEF_RST_CYCLES   = 2;
    localparam int DEF_DRAIN_CYCLES = 2;
    localparam int DEF_MAX_CYCLES   = 65535;
    typedef enum logic [RUN_STATE_W-1:0] {
        IDLE       = 3'd0,
        RESET_PIPE = 3'd1,
        RUN        = 3'd2,
        STEP_WAIT  = 3'd3,
        STEP_EXEC  = 3'd4,
        DRAIN      = 3'd5,
        DUMP       = 3'd6,
        DONE       = 3'd7
    } run_state_t;
endpackage

// File: rtl/pipeline_run_controller_rise_detect.sv
// rise_detect: one-cycle rising-edge pulse with history cleared by async reset.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic pulse_o
);
    logic prev_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) prev_q <= 1'b0;
        else     prev_q <= d_i;
    assign pulse_o = d_i & ~prev_q;
endmodule

// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller: run-control FSM gating pipeline enable/reset, single-step, cycle count and dump handshake.
// Optional watchdog enabled by defining CYCLE_LIMIT_EN.
module pipeline_run_controller
    import pipeline_run_controller_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int CNT_W        = 32
`ifdef CYCLE_LIMIT_EN
    ,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES
`endif
) (
    input  logic                   pipeClk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   step_mode,
    input  logic                   step_req,
    input  logic                   program_end,
    input  logic                   dump_ack,
    output logic                   pipe_en,
    output logic                   pipe_reset,
    output logic                   dump_req,
    output logic                   done,
    output logic                   timeout,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [RUN_STATE_W-1:0] state
);
    localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
    localparam run_state_t  DRAIN_TGT  = (DRAIN_CYCLES == 0) ? DUMP : DRAIN;
    run_state_t       state_q, state_d;
    logic [15:0]      phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic             start_rise, step_rise, limit_hit, run_clr;
    rise_detect u_start_rd (.clk(pipeClk), .rst(reset), .d_i(start),    .pulse_o(start_rise));
    rise_detect u_step_rd  (.clk(pipeClk), .rst(reset), .d_i(step_req), .pulse_o(step_rise));
    assign count_inc = (&count_q) ? count_q : count_q + 1'b1;
    assign run_clr   = start_rise && (state_q == IDLE || state_q == DONE);
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start_rise ? RESET_PIPE : state_q;
            RESET_PIPE: state_d = (phase_q != RST_LAST) ? RESET_PIPE : step_mode ? STEP_WAIT : RUN;
            RUN:        state_d = (program_end || limit_hit) ? DRAIN_TGT : step_mode ? STEP_WAIT : RUN;
            STEP_WAIT:  state_d = program_end ? DRAIN_TGT : !step_mode ? RUN : step_rise ? STEP_EXEC : STEP_WAIT;
            STEP_EXEC:  state_d = limit_hit ? DRAIN_TGT : STEP_WAIT;
            DRAIN:      state_d = (phase_q == DRAIN_LAST) ? DUMP : DRAIN;
            DUMP:       state_d = dump_ack ? DONE : DUMP;
        endcase
        phase_d = (state_d != state_q) ? '0 : phase_q + 1'b1;
        count_d = run_clr ? '0 : pipe_en ? count_inc : count_q;
    end
    always_ff @(posedge pipeClk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
        end
`ifdef CYCLE_LIMIT_EN
    logic timeout_q;
    assign limit_hit = (count_inc == CNT_W'(MAX_CYCLES)) && !program_end;
    always_ff @(posedge pipeClk or posedge reset)
        if (reset)                                                   timeout_q <= 1'b0;
        else if (run_clr)                                            timeout_q <= 1'b0;
        else if (limit_hit && (state_q == RUN || state_q == STEP_EXEC)) timeout_q <= 1'b1;
    assign timeout = timeout_q;
`else
    assign limit_hit = 1'b0;
    assign timeout   = 1'b0;
`endif
    assign pipe_en     = state_q inside {RUN, STEP_EXEC, DRAIN};
    assign pipe_reset  = state_q inside {IDLE, RESET_PIPE};
    assign dump_req    = state_q == DUMP;
    assign done        = state_q == DONE;
    assign cycle_count = count_q;
    assign state       = state_q;
endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb_pipeline_run_controller: directed self-checking bench for pipeline_run_controller.
module tb_pipeline_run_controller;
    logic        pipeClk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, step_mode = 1'b0, step_req = 1'b0;
    logic        program_end = 1'b0, dump_ack = 1'b0;
    logic        pipe_en, pipe_reset, dump_req, done, timeout;
    logic [31:0] cycle_count;
    logic [2:0]  state;
    int          checks = 0, errors = 0, en_cnt = 0;

    pipeline_run_controller #(
        .RST_CYCLES(2), .DRAIN_CYCLES(2), .CNT_W(32)
`ifdef CYCLE_LIMIT_EN
        , .MAX_CYCLES(16)
`endif
    ) dut (
        .pipeClk(pipeClk), .reset(reset), .start(start), .step_mode(step_mode),
        .step_req(step_req), .program_end(program_end), .dump_ack(dump_ack),
        .pipe_en(pipe_en), .pipe_reset(pipe_reset), .dump_req(dump_req), .done(done),
        .timeout(timeout), .cycle_count(cycle_count), .state(state)
    );

    always #5 pipeClk = ~pipeClk;

    task automatic tick();
        @(posedge pipeClk);
        #1;
        if (pipe_en) en_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2;
        chk("rst_state", 32'(state), 0);
        chk("rst_pipe_reset", 32'(pipe_reset), 1);
        chk("rst_pipe_en", 32'(pipe_en), 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_dump_req", 32'(dump_req), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_timeout", 32'(timeout), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("idle_hold", 32'(state), 0);

        // start pulse: two reset cycles, then RUN
        start = 1'b1;
        tick();
        chk("rp1_state", 32'(state), 1);
        chk("rp1_pipe_reset", 32'(pipe_reset), 1);
        start = 1'b0;
        tick();
        chk("rp2_pipe_reset", 32'(pipe_reset), 1);
        chk("rp2_pipe_en", 32'(pipe_en), 0);
        tick();
        chk("run_state", 32'(state), 2);
        chk("run_pipe_en", 32'(pipe_en), 1);
        chk("run_pipe_reset", 32'(pipe_reset), 0);
        chk("run_dump_req", 32'(dump_req), 0);
        chk("run_done", 32'(done), 0);

        // free-run 10 cycles then program_end
        repeat (9) tick();
        chk("run9_count", cycle_count, 9);
        program_end = 1'b1;
        tick();
        chk("drain1_state", 32'(state), 5);
        chk("drain1_pipe_en", 32'(pipe_en), 1);
        chk("drain1_count", cycle_count, 10);
        tick();
        chk("drain2_state", 32'(state), 5);
        chk("drain2_count", cycle_count, 11);
        tick();
        chk("dump_state", 32'(state), 6);
        chk("dump_req", 32'(dump_req), 1);
        chk("dump_pipe_en", 32'(pipe_en), 0);
        chk("dump_count", cycle_count, 12);
        tick();
        tick();
        chk("dump_wait", 32'(dump_req), 1);
        dump_ack = 1'b1;
        tick();
        dump_ack = 1'b0;
        program_end = 1'b0;
        chk("done_state", 32'(state), 7);
        chk("done_flag", 32'(done), 1);
        chk("done_dump_req", 32'(dump_req), 0);
        chk("done_count", cycle_count, 12);
        chk("done_pipe_reset", 32'(pipe_reset), 0);

        // restart from DONE into single-step mode
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_state", 32'(state), 1);
        chk("restart_count", cycle_count, 0);
        tick();
        tick();
        chk("sw_state", 32'(state), 3);
        chk("sw_pipe_en", 32'(pipe_en), 0);
        tick();
        en_cnt = 0;
        step_req = 1'b1;
        tick();
        chk("se1_state", 32'(state), 4);
        step_req = 1'b0;
        tick();
        step_req = 1'b1;
        repeat (5) tick();
        chk("held_state", 32'(state), 3);
        chk("held_count", cycle_count, 2);
        step_req = 1'b0;
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        chk("step_en_cycles", en_cnt, 3);
        chk("step_count", cycle_count, 3);
        chk("step_back_wait", 32'(state), 3);
        step_mode = 1'b0;
        tick();
        chk("resume_state", 32'(state), 2);
        tick();
        chk("resume_count", cycle_count, 4);

        // start edge during RUN is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_run", 32'(state), 2);
        chk("start_in_run_count", cycle_count, 5);

        // program_end beats step_mode in the same cycle
        program_end = 1'b1;
        step_mode = 1'b1;
        tick();
        program_end = 1'b0;
        step_mode = 1'b0;
        chk("prio_state", 32'(state), 5);
        tick();
        tick();
        chk("prio_dump", 32'(state), 6);
        chk("prio_count", cycle_count, 8);
        dump_ack = 1'b1;
        tick();
        dump_ack = 1'b0;
        chk("prio_done", 32'(state), 7);

        // async reset between edges mid-RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_areset_count", cycle_count, 2);
        #3 reset = 1'b1;
        #1;
        chk("areset_state", 32'(state), 0);
        chk("areset_pipe_en", 32'(pipe_en), 0);
        chk("areset_pipe_reset", 32'(pipe_reset), 1);
        chk("areset_count", cycle_count, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_areset", 32'(state), 0);

        // watchdog boundary at 16 cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        repeat (15) tick();
        chk("wd15_state", 32'(state), 2);
        chk("wd15_count", cycle_count, 15);
        chk("wd15_timeout", 32'(timeout), 0);
        tick();
        chk("wd16_count", cycle_count, 16);
`ifdef CYCLE_LIMIT_EN
        chk("wd16_state", 32'(state), 5);
        chk("wd16_timeout", 32'(timeout), 1);
        tick();
        tick();
        chk("wd_dump", 32'(state), 6);
        dump_ack = 1'b1;
        tick();
        dump_ack = 1'b0;
        chk("wd_done", 32'(state), 7);
        chk("wd_sticky", 32'(timeout), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wd_clear", 32'(timeout), 0);
`else
        chk("wd16_state", 32'(state), 2);
        chk("wd16_timeout", 32'(timeout), 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
